decoder_8_256: RTL and testbench

- Registered 8-to-256 one-hot decoder. It is the inverse of the team's 256-to-8 encoder: `encoder_256(decoder_8_256(code)) == code`.
- Two modes:
  - Single-code mode: a valid/ready handshake.
  - Self-running scan mode: walks every code 0..255 with a programmable dwell. Used for row/line-select driving and for encoder round-trip self-test.

---
 rtl/decoder_8_256_if.sv | 24 ++
 rtl/decoder_8_256.sv | 98 +++++++++
 tb/tb_decoder_8_256.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_8_256_if.sv
// Code handshake and decoded-output bundle for decoder_8_256.
// Handshake: a code transfers on a rising clk edge where code_valid && code_ready are both high.
interface decoder_8_256_if #(
  parameter int SEL_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic [SEL_W-1:0] code;
  logic             code_valid;
  logic             code_ready;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] out_code;
  logic             out_valid;

  modport master (
    output code, code_valid,
    input  code_ready, out, out_code, out_valid
  );

  modport slave (
    input  code, code_valid,
    output code_ready, out, out_code, out_valid
  );
endinterface

// File: rtl/decoder_8_256.sv
// Registered one-hot decoder with a single-code handshake mode and a self-running
// scan that walks every code with a programmable dwell.
module decoder_8_256 #(
  parameter int SEL_W = 8,
  parameter int DWELL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_8_256_if.slave     bus,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_done,
  output logic [1:0]         dbg_state
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] ONE       = OUT_W'(1);
  localparam logic [SEL_W:0]   IDX_ONE   = (SEL_W + 1)'(1);
  localparam logic [15:0]      DWELL_END = 16'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [15:0]    dwell_cnt;
  logic [SEL_W:0] idx;
  logic [SEL_W:0] idx_nxt;

  assign idx_nxt   = idx + IDX_ONE;
  assign dbg_state = state;

  always_comb begin
    bus.code_ready = (state == IDLE) && !scan_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dwell_cnt     <= '0;
      idx           <= '0;
      bus.out       <= '0;
      bus.out_code  <= '0;
      bus.out_valid <= 1'b0;
      scan_busy     <= 1'b0;
      scan_done     <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      scan_done     <= 1'b0;
      case (state)
        IDLE: begin
          // A scan request takes priority; code_ready is already low so no code is lost.
          if (scan_start) begin
            state         <= SCAN;
            idx           <= '0;
            dwell_cnt     <= '0;
            bus.out       <= ONE;
            bus.out_code  <= '0;
            bus.out_valid <= 1'b1;
            scan_busy     <= 1'b1;
          end else if (bus.code_valid) begin
            bus.out       <= ONE << bus.code;
            bus.out_code  <= bus.code;
            bus.out_valid <= 1'b1;
          end
        end
        SCAN: begin
          if (dwell_cnt == DWELL_END) begin
            dwell_cnt <= '0;
            idx       <= idx_nxt;
            // The extra index bit flags that the last code has finished its dwell.
            if (idx_nxt[SEL_W]) begin
              state        <= DONE;
              bus.out      <= '0;
              bus.out_code <= '0;
              scan_busy    <= 1'b0;
              scan_done    <= 1'b1;
            end else begin
              bus.out       <= ONE << idx_nxt[SEL_W-1:0];
              bus.out_code  <= idx_nxt[SEL_W-1:0];
              bus.out_valid <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_8_256.sv
// Scoreboard bench for decoder_8_256: one instance with DWELL=1, one with DWELL=3.
module tb_decoder_8_256;
  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  logic busy1, busy3, done1, done3;
  logic [1:0] st1, st3;

  decoder_8_256_if #(.SEL_W(8)) b1 ();
  decoder_8_256_if #(.SEL_W(8)) b3 ();

  decoder_8_256 #(.SEL_W(8), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .scan_start(start1),
    .scan_busy(busy1), .scan_done(done1), .dbg_state(st1)
  );
  decoder_8_256 #(.SEL_W(8), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .scan_start(start3),
    .scan_busy(busy3), .scan_done(done3), .dbg_state(st3)
  );

  always #5 clk = ~clk;

  logic [7:0] exp1_q[$];
  logic [7:0] exp3_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Selected instance for the shared scan task
  logic sel3 = 1'b0;
  wire         m_busy  = sel3 ? busy3 : busy1;
  wire         m_done  = sel3 ? done3 : done1;
  wire [1:0]   m_state = sel3 ? st3 : st1;
  wire         m_valid = sel3 ? b3.out_valid : b1.out_valid;
  wire         m_ready = sel3 ? b3.code_ready : b1.code_ready;
  wire [7:0]   m_code  = sel3 ? b3.out_code : b1.out_code;
  wire [255:0] m_out   = sel3 ? b3.out : b1.out;

  function automatic logic [255:0] onehot(input int c);
    logic [255:0] v;
    v = 256'd1;
    return v << c;
  endfunction

  // Reference 256-to-8 encoder used for the round-trip check
  function automatic logic [7:0] enc256(input logic [255:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) if (v[i]) r = 8'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected code whenever a decoder presents a new output
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n === 1'b1 && b1.out_valid === 1'b1) begin
      if (exp1_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dec1_unexpected: got out_code %0h expected no output", b1.out_code);
      end else begin
        e = exp1_q.pop_front();
        chk("dec1_out", b1.out, onehot(int'(e)));
        chk("dec1_out_code", 256'(b1.out_code), 256'(e));
        chk("dec1_roundtrip", 256'(enc256(b1.out)), 256'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n === 1'b1 && b3.out_valid === 1'b1) begin
      if (exp3_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dec3_unexpected: got out_code %0h expected no output", b3.out_code);
      end else begin
        e = exp3_q.pop_front();
        chk("dec3_out", b3.out, onehot(int'(e)));
        chk("dec3_out_code", 256'(b3.out_code), 256'(e));
      end
    end
  end

  // Caller is just after a rising edge. Runs one full scan on the selected instance.
  task automatic scan_run(input int d, input bit collide, input bit poke_done);
    sel3 = (d != 1);
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (sel3) exp3_q.push_back(8'(i)); else exp1_q.push_back(8'(i));
    end
    if (collide) begin
      b1.code = 8'h42;
      b1.code_valid = 1'b1;
      exp1_q.push_back(8'h42);
    end
    @(negedge clk);
    chk("start_ready_low", 256'(m_ready), 256'(0));
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    for (int k = 0; k < 256 * d; k++) begin
      @(negedge clk);
      chk("scan_busy", 256'(m_busy), 256'(1));
      chk("scan_valid", 256'(m_valid), 256'((k % d) == 0));
      chk("scan_index", 256'(m_code), 256'(k / d));
      if (k == 0) chk("scan_state", 256'(m_state), 256'(1));
      if (d == 1) chk("scan_ready_low", 256'(m_ready), 256'(0));
      @(posedge clk); #1;
    end
    if (poke_done) begin
      if (sel3) start3 = 1'b1; else start1 = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", 256'(m_done), 256'(1));
    chk("done_out_zero", m_out, 256'(0));
    chk("done_busy_low", 256'(m_busy), 256'(0));
    chk("done_valid_low", 256'(m_valid), 256'(0));
    chk("done_ready_low", 256'(m_ready), 256'(0));
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
    chk("post_done_clear", 256'(m_done), 256'(0));
    chk("post_state_idle", 256'(m_state), 256'(0));
    chk("post_ready", 256'(m_ready), 256'(1));
    @(posedge clk); #1;
    b1.code_valid = 1'b0;
    @(negedge clk);
    chk("no_restart_busy", 256'(m_busy), 256'(0));
    chk("no_restart_state", 256'(m_state), 256'(0));
    if (collide) chk("held_code_decoded", 256'(b1.out_code), 256'(8'h42));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] vec[3];
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'hA5;
    rst_n = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    b1.code = '0; b1.code_valid = 1'b0;
    b3.code = '0; b3.code_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", b1.out, 256'(0));
    chk("rst_out_code", 256'(b1.out_code), 256'(0));
    chk("rst_valid", 256'(b1.out_valid), 256'(0));
    chk("rst_busy", 256'(busy1), 256'(0));
    chk("rst_done", 256'(done1), 256'(0));
    chk("rst_state", 256'(st1), 256'(0));
    chk("rst_ready", 256'(b1.code_ready), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back decode of three directed codes
    for (int i = 0; i < 3; i++) begin
      b1.code = vec[i];
      b1.code_valid = 1'b1;
      exp1_q.push_back(vec[i]);
      @(negedge clk);
      chk("dec_ready", 256'(b1.code_ready), 256'(1));
      if (i > 0) begin
        chk("b2b_valid", 256'(b1.out_valid), 256'(1));
        chk("b2b_latency", 256'(b1.out_code), 256'(vec[i-1]));
      end
      @(posedge clk); #1;
    end
    b1.code_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_last", 256'(b1.out_valid), 256'(1));
    chk("b2b_out_a5", b1.out, onehot(165));
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_valid_drop", 256'(b1.out_valid), 256'(0));
    chk("b2b_hold", b1.out, onehot(165));
    @(posedge clk); #1;

    // Exhaustive round trip
    for (int c = 0; c < 256; c++) begin
      b1.code = 8'(c);
      b1.code_valid = 1'b1;
      exp1_q.push_back(8'(c));
      @(posedge clk); #1;
    end
    b1.code_valid = 1'b0;
    @(posedge clk); #1;

    // Hold: one accept then idle
    b1.code = 8'h10;
    b1.code_valid = 1'b1;
    exp1_q.push_back(8'h10);
    @(posedge clk); #1;
    b1.code_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out", b1.out, onehot(16));
      chk("hold_valid", 256'(b1.out_valid), 256'(0));
    end
    @(posedge clk); #1;

    scan_run(1, 1'b0, 1'b0);
    scan_run(1, 1'b1, 1'b0);
    scan_run(1, 1'b0, 1'b1);
    scan_run(3, 1'b0, 1'b0);

    // Reset in the middle of a scan, then restart
    sel3 = 1'b0;
    start1 = 1'b1;
    for (int i = 0; i < 256; i++) exp1_q.push_back(8'(i));
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_index", 256'(b1.out_code), 256'(100));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp1_q.delete();
    @(negedge clk);
    chk("mid_rst_out", b1.out, 256'(0));
    chk("mid_rst_busy", 256'(busy1), 256'(0));
    chk("mid_rst_state", 256'(st1), 256'(0));
    chk("mid_rst_valid", 256'(b1.out_valid), 256'(0));
    @(posedge clk); #1;
    scan_run(1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("q1_drained", 256'(exp1_q.size()), 256'(0));
    chk("q3_drained", 256'(exp3_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
